// File: rtl/lsu_mem_access.sv
// Load/store unit: runs one request/ready transaction to data memory per accepted op,
// steering store lanes and extending load data; faults on bad size, misalignment or timeout.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] load_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StFault} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [3:0]      wstrb_q, wstrb_d;
  logic [31:0]     load_q, load_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [1:0]      off_q, off_d;

  logic            accept;
  logic            load_ok, store_ok, op_ok, misaligned;
  logic [31:0]     st_wdata;
  logic [3:0]      st_wstrb;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ext_data;
  logic [CntW-1:0] cnt_inc;

  assign accept = start & (mem_read | mem_write) & (state_q == StIdle);

  always_comb begin
    load_ok  = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    store_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    // Both direction bits set is never a legal op.
    op_ok    = (mem_read ^ mem_write) & (mem_read ? load_ok : store_ok);
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  always_comb begin
    unique case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        st_wdata = store_data;
        st_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    rbyte = dmem_rdata[{off_q, 3'b000} +: 8];
    rhalf = dmem_rdata[{off_q[1], 4'b0000} +: 16];
    unique case (size_q)
      2'b00:   ext_data = {{24{~uns_q & rbyte[7]}}, rbyte};
      2'b01:   ext_data = {{16{~uns_q & rhalf[15]}}, rhalf};
      default: ext_data = dmem_rdata;
    endcase
  end

  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    load_d  = load_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    uns_d   = uns_q;
    off_d   = off_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (op_ok && !misaligned) begin
            req_d   = 1'b1;
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            wdata_d = st_wdata;
            wstrb_d = mem_write ? st_wstrb : 4'b0000;
            cnt_d   = '0;
            size_d  = funct3[1:0];
            uns_d   = funct3[2];
            off_d   = addr[1:0];
            state_d = StReq;
          end else begin
            state_d = StFault;
          end
        end
      end
      StReq: begin
        if (dmem_ready) begin
          if (!we_q) load_d = ext_data;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CntW'(TIMEOUT_CYCLES)) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = StFault;
          end
        end
      end
      StDone:  state_d = StIdle;
      StFault: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      load_q  <= '0;
      cnt_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      load_q  <= load_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      off_q   <= off_d;
    end
  end

  // Stall drops in the DONE/FAULT cycle so the core advances exactly once.
  assign stall      = accept | (state_q == StReq);
  assign done       = (state_q == StDone) | (state_q == StFault);
  assign fault      = (state_q == StFault);
  assign load_data  = load_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_wstrb = wstrb_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: table of single-cycle-ready transactions plus
// hand-written sequences for delayed ready, timeout and mid-transaction reset.
module tb_lsu_mem_access;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        fault;
  logic [31:0] load_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  lsu_mem_access #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .stall      (stall),
    .done       (done),
    .fault      (fault),
    .load_data  (load_data),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [31:0] rdata;
    logic        fault;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic [31:0] load;
  } vec_t;

  localparam int NVec = 17;
  vec_t vecs [NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " stall"}, {31'b0, stall}, 32'd0);
    chk({tag, " done"}, {31'b0, done}, 32'd0);
    chk({tag, " fault"}, {31'b0, fault}, 32'd0);
    chk({tag, " req"}, {31'b0, dmem_req}, 32'd0);
    chk({tag, " we"}, {31'b0, dmem_we}, 32'd0);
    chk({tag, " load_data"}, load_data, 32'd0);
    chk({tag, " dmem_addr"}, dmem_addr, 32'd0);
    chk({tag, " dmem_wdata"}, dmem_wdata, 32'd0);
    chk({tag, " dmem_wstrb"}, {28'b0, dmem_wstrb}, 32'd0);
  endtask

  task automatic drive_op(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd);
    start = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
  endtask

  task automatic drop_op();
    start = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t  v;
    string n;
    v = vecs[i];
    n = $sformatf("v%0d", i);
    @(posedge clk); #1;
    drive_op(v.rd, v.wr, v.f3, v.addr, v.sdata);
    dmem_ready = 1'b1;
    dmem_rdata = v.rdata;
    @(negedge clk);
    chk({n, " c0 stall"}, {31'b0, stall}, 32'd1);
    chk({n, " c0 req"}, {31'b0, dmem_req}, 32'd0);
    @(posedge clk); #1;
    drop_op();
    @(negedge clk);
    if (v.fault) begin
      chk({n, " fault done"}, {31'b0, done}, 32'd1);
      chk({n, " fault flag"}, {31'b0, fault}, 32'd1);
      chk({n, " fault req"}, {31'b0, dmem_req}, 32'd0);
      chk({n, " fault stall"}, {31'b0, stall}, 32'd0);
      chk({n, " fault load"}, load_data, v.load);
    end else begin
      chk({n, " req"}, {31'b0, dmem_req}, 32'd1);
      chk({n, " we"}, {31'b0, dmem_we}, {31'b0, v.wr});
      chk({n, " addr"}, dmem_addr, {v.addr[31:2], 2'b00});
      chk({n, " wstrb"}, {28'b0, dmem_wstrb}, {28'b0, v.strb});
      if (v.wr) chk({n, " wdata"}, dmem_wdata, v.wdata);
      chk({n, " c1 stall"}, {31'b0, stall}, 32'd1);
      chk({n, " c1 done"}, {31'b0, done}, 32'd0);
      @(posedge clk); @(negedge clk);
      chk({n, " done"}, {31'b0, done}, 32'd1);
      chk({n, " fault"}, {31'b0, fault}, 32'd0);
      chk({n, " c2 stall"}, {31'b0, stall}, 32'd0);
      chk({n, " c2 req"}, {31'b0, dmem_req}, 32'd0);
      chk({n, " load"}, load_data, v.load);
    end
    dmem_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    //            rd    wr    f3    addr        sdata         rdata         flt   strb  wdata         load
    vecs[0]  = '{1'b0, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 4'hF, 32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b0, 1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0,        1'b0, 4'h8, 32'hA5A5A5A5, 32'h0};
    vecs[2]  = '{1'b1, 1'b0, 3'd0, 32'h103, 32'h0,        32'hA5000000, 1'b0, 4'h0, 32'h0, 32'hFFFFFFA5};
    vecs[3]  = '{1'b1, 1'b0, 3'd4, 32'h103, 32'h0,        32'hA5000000, 1'b0, 4'h0, 32'h0, 32'h000000A5};
    vecs[4]  = '{1'b1, 1'b0, 3'd1, 32'h202, 32'h0,        32'h80011234, 1'b0, 4'h0, 32'h0, 32'hFFFF8001};
    vecs[5]  = '{1'b1, 1'b0, 3'd5, 32'h200, 32'h0,        32'h80011234, 1'b0, 4'h0, 32'h0, 32'h00001234};
    vecs[6]  = '{1'b1, 1'b0, 3'd2, 32'h204, 32'h0,        32'h12345678, 1'b0, 4'h0, 32'h0, 32'h12345678};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 32'h102, 32'h0000BEEF, 32'h0,        1'b0, 4'hC, 32'hBEEFBEEF, 32'h12345678};
    vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'h101, 32'h0000003C, 32'h0,        1'b0, 4'h2, 32'h3C3C3C3C, 32'h12345678};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 32'h101, 32'h0,        32'h00007F00, 1'b0, 4'h0, 32'h0, 32'h0000007F};
    vecs[10] = '{1'b1, 1'b0, 3'd2, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[11] = '{1'b1, 1'b0, 3'd3, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[12] = '{1'b1, 1'b1, 3'd2, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[13] = '{1'b0, 1'b1, 3'd4, 32'h100, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[14] = '{1'b0, 1'b1, 3'd1, 32'h101, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[15] = '{1'b1, 1'b0, 3'd1, 32'h203, 32'h0,        32'h0,        1'b1, 4'h0, 32'h0, 32'h0000007F};
    vecs[16] = '{1'b1, 1'b0, 3'd5, 32'h206, 32'h0,        32'hFEDC0000, 1'b0, 4'h0, 32'h0, 32'h0000FEDC};

    reset = 1'b1; drop_op(); funct3 = 3'd0; addr = '0; store_data = '0;
    dmem_ready = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // start with neither direction bit, plus a stray ready while idle
    start = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    chk("nop stall", {31'b0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("nop req", {31'b0, dmem_req}, 32'd0);
    chk("nop done", {31'b0, done}, 32'd0);
    dmem_ready = 1'b0;

    for (int i = 0; i < NVec; i++) run_vec(i);

    // LH with ready delayed: request must hold stable for 3 cycles, done exactly once
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 3'd1, 32'h202, 32'h0);
    dmem_rdata = 32'h80011234;
    @(posedge clk); #1;
    drop_op();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("dly%0d req", k), {31'b0, dmem_req}, 32'd1);
      chk($sformatf("dly%0d addr", k), dmem_addr, 32'h200);
      chk($sformatf("dly%0d wstrb", k), {28'b0, dmem_wstrb}, 32'd0);
      chk($sformatf("dly%0d stall", k), {31'b0, stall}, 32'd1);
      chk($sformatf("dly%0d done", k), {31'b0, done}, 32'd0);
      @(posedge clk); #1;
    end
    dmem_ready = 1'b1;
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done) cnt++;
    end
    chk("dly done count", cnt, 32'd1);
    chk("dly load", load_data, 32'hFFFF8001);

    // LW with ready stuck low: 16 REQ cycles then a fault pulse
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 3'd2, 32'h300, 32'h0);
    @(posedge clk); #1;
    drop_op();
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!dmem_req) break;
      cnt++;
    end
    chk("to req cycles", cnt, 32'd16);
    chk("to done", {31'b0, done}, 32'd1);
    chk("to fault", {31'b0, fault}, 32'd1);
    chk("to load", load_data, 32'hFFFF8001);
    @(negedge clk);
    chk("to pulse end", {31'b0, done}, 32'd0);

    // reset in the 2nd REQ cycle of a load
    @(posedge clk); #1;
    drive_op(1'b1, 1'b0, 3'd2, 32'h400, 32'h0);
    @(posedge clk); #1;
    drop_op();
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst pre req", {31'b0, dmem_req}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst mid");
    @(negedge clk);
    chk("rst no done", {31'b0, done}, 32'd0);
    @(posedge clk); #1;
    drive_op(1'b0, 1'b1, 3'd2, 32'h500, 32'h11223344);
    dmem_ready = 1'b1;
    @(negedge clk);
    chk("post rst stall", {31'b0, stall}, 32'd1);
    @(posedge clk); #1;
    drop_op();
    @(negedge clk);
    chk("post rst req", {31'b0, dmem_req}, 32'd1);
    chk("post rst addr", dmem_addr, 32'h500);
    chk("post rst wdata", dmem_wdata, 32'h11223344);
    @(posedge clk); @(negedge clk);
    chk("post rst done", {31'b0, done}, 32'd1);
    dmem_ready = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
